// File: rtl/src_regfile.sv
// Coefficient/sample register file for the sample-rate-converter datapath: 2 registered read ports, 1 write port, self-clear after reset.
// Optional stored-parity checking is enabled by defining SRC_RF_PARITY_EN.
module src_regfile #(
  parameter int AW = 3,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          re1,
  input  logic          re2,
  input  logic          we,
  input  logic [AW-1:0] ar1,
  input  logic [AW-1:0] ar2,
  input  logic [AW-1:0] ard,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          rvalid,
`ifdef SRC_RF_PARITY_EN
  output logic          rd1_perr,
  output logic          rd2_perr,
`endif
  output logic          ready
);

  localparam int DEPTH = 1 << AW;
`ifdef SRC_RF_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

`ifdef SRC_RF_PARITY_EN
  function automatic logic parity_f(input logic [DW-1:0] d);
    parity_f = ^d;
  endfunction
`endif

  state_e          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [DW-1:0]   rd1_q, rd1_d;
  logic [DW-1:0]   rd2_q, rd2_d;
  logic            rvalid_q, rvalid_d;
  logic            ready_q, ready_d;
  logic [MW-1:0]   mem_q [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [MW-1:0]   mem_wdata;
  logic [MW-1:0]   wr_word;
  logic [MW-1:0]   rd1_word;
  logic [MW-1:0]   rd2_word;
  logic            bypass1;
  logic            bypass2;
`ifdef SRC_RF_PARITY_EN
  logic            perr1_q, perr1_d;
  logic            perr2_q, perr2_d;
`endif

`ifdef SRC_RF_PARITY_EN
  assign wr_word = {parity_f(wdata), wdata};
`else
  assign wr_word = wdata;
`endif

  assign rd1_word = mem_q[ar1];
  assign rd2_word = mem_q[ar2];
  // A same-cycle write to the read address forwards the new data, never the stale entry.
  assign bypass1  = we && (ar1 == ard);
  assign bypass2  = we && (ar2 == ard);

  // Next-state, memory write port and read-data selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    rvalid_d  = 1'b0;
    ready_d   = (state_q == ST_RUN);
    mem_we    = 1'b0;
    mem_waddr = ard;
    mem_wdata = wr_word;
`ifdef SRC_RF_PARITY_EN
    perr1_d   = perr1_q;
    perr2_d   = perr2_q;
`endif
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[AW-1:0];
        mem_wdata = {MW{1'b0}};
        cnt_d     = cnt_q + {{AW{1'b0}}, 1'b1};
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN: begin
        // Accesses open one cycle after entering RUN, when ready is visible.
        if (en && ready_q) begin
          mem_we   = we;
          rvalid_d = re1 | re2;
          if (re1) begin
            if (bypass1) begin
              rd1_d = wdata;
`ifdef SRC_RF_PARITY_EN
              perr1_d = 1'b0;
`endif
            end else begin
              rd1_d = rd1_word[DW-1:0];
`ifdef SRC_RF_PARITY_EN
              perr1_d = ^rd1_word;
`endif
            end
          end else begin
            rd1_d = rd1_q;
          end
          if (re2) begin
            if (bypass2) begin
              rd2_d = wdata;
`ifdef SRC_RF_PARITY_EN
              perr2_d = 1'b0;
`endif
            end else begin
              rd2_d = rd2_word[DW-1:0];
`ifdef SRC_RF_PARITY_EN
              perr2_d = ^rd2_word;
`endif
            end
          end else begin
            rd2_d = rd2_q;
          end
        end else begin
          mem_we   = 1'b0;
          rvalid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = {(AW+1){1'b0}};
      end
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= {(AW+1){1'b0}};
      rd1_q    <= {DW{1'b0}};
      rd2_q    <= {DW{1'b0}};
      rvalid_q <= 1'b0;
      ready_q  <= 1'b0;
`ifdef SRC_RF_PARITY_EN
      perr1_q  <= 1'b0;
      perr2_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      rvalid_q <= rvalid_d;
      ready_q  <= ready_d;
`ifdef SRC_RF_PARITY_EN
      perr1_q  <= perr1_d;
      perr2_q  <= perr2_d;
`endif
    end
  end

  // Storage array; contents are zeroed by the CLEAR sequence, not by reset.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd1    = rd1_q;
  assign rd2    = rd2_q;
  assign rvalid = rvalid_q;
  assign ready  = ready_q;
`ifdef SRC_RF_PARITY_EN
  assign rd1_perr = perr1_q;
  assign rd2_perr = perr2_q;
`endif

endmodule
